buck_pwm_gen: RTL and testbench
===============================

BUCK_PWM_GEN -- requirements
Module: buck_pwm_gen

Interface
REQ-001 SHALL have parameter PERIOD, 16'd400, PWM period in clk cycles (4 us at 100 MHz).
REQ-002 SHALL have parameter MAX_ON, 16'd360, upper clamp on on-time in clk cycles.
REQ-003 SHALL have parameter MIN_ON, 16'd8, lower clamp on any non-zero on-time.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port current_state  input  8  discharge FSM state (one-hot encoding, S_DEION = 8'b10000000).
REQ-007 SHALL have port charging_time_0  input  16  requested phase-0 on-time, from open-loop or closed-loop control.
REQ-008 SHALL have port charging_time_1  input  16  requested phase-1 on-time.
REQ-009 SHALL have port oc_fault  input  1  synchronous overcurrent comparator flag, high = trip.
REQ-010 SHALL have port timer_buck_4us_0  output  16  phase-0 period counter.
REQ-011 SHALL have port timer_buck_4us_1  output  16  phase-1 period counter, offset by half a period.
REQ-012 SHALL have port gate_0 / gate_1  output  1 each  buck MOSFET gate drive, high = on.
REQ-013 SHALL have port cycle_start_0  output  1  one-clk pulse when timer_buck_4us_0 == 0.

Function
REQ-014 timer_buck_4us_0 SHALL count 0..PERIOD-1 and wrap to 0; it free-runs in every state.
REQ-015 timer_buck_4us_1 SHALL count identically, starting from PERIOD/2 out of reset.
REQ-016 Enable SHALL be true only when current_state is S_WAIT_BREAKDOWN (8'b00000001) or S_BUCK_INTERLEAVE (8'b00000010).
REQ-017 Per phase, when timer == PERIOD-1, the shadow on_time SHALL load clamp(charging_time) and apply from timer == 0; mid-cycle input changes SHALL NOT take effect.
REQ-018 clamp SHALL be: 0 -> 0; 1..MIN_ON-1 -> MIN_ON; above MAX_ON -> MAX_ON; otherwise unchanged (unsigned 16-bit compare).
REQ-019 Per phase, an arm flag SHALL set at timer == PERIOD-1 if enable is high, and clear immediately (next clk) when enable is low.
REQ-020 Enable rising mid-cycle SHALL NOT start a pulse; the first pulse begins at the next timer == 0.
REQ-021 gate_x SHALL be registered: gate_x = arm_x AND enable AND (timer_x < on_time_x) AND NOT oc_latch_x, with one clk latency from timer value.
REQ-022 oc_fault high SHALL set oc_latch for both phases; the gate falls on the next clk and stays low for the rest of that phase's cycle.
REQ-023 oc_latch_x SHALL clear at timer_x == PERIOD-1; if oc_fault is high on that same clk, set SHALL win.
REQ-024 on_time == 0 SHALL hold the gate low for the whole cycle; on_time is never PERIOD or more, so there is always an off interval.

Reset
REQ-025 On rst_n low: timer_0 = 0, timer_1 = PERIOD/2, on_time = 0, arm = 0, oc_latch = 0, gate_0 = gate_1 = 0, cycle_start_0 = 0.
REQ-026 Reset asserted mid-pulse SHALL drop gates asynchronously; after release, no pulse before the first full armed cycle.

Configuration
REQ-027 With INTERLEAVE_PHASE1_EN defined, phase 1 SHALL operate per REQ-015..024.
REQ-028 Without INTERLEAVE_PHASE1_EN, timer_buck_4us_1 SHALL be constant 0, gate_1 SHALL be constant 0, and charging_time_1 SHALL be ignored.

Structure
REQ-029 The state encodings and the PERIOD, MAX_ON and MIN_ON defaults SHALL live in shared package buck_pkg.
REQ-030 Per-phase logic SHALL be sub-module buck_pwm_phase, instantiated once or twice. It contains the timer, shadow, clamp, arm, oc_latch and gate.

Verification
REQ-031 Setup: state = 8'b00000010, charging_time_0 = 120. Response: gate_0 is high 120 clk per period from the second period onward; cycle_start_0 is pulsed every 400 clk.
REQ-032 Setup: charging_time_0 changes 120 -> 80 at timer = 50. Response: the current pulse stays 120; the next pulse is 80.
REQ-033 Clamp cases: charging_time 3 -> pulse 8; charging_time 500 -> pulse 360; charging_time 0 -> gate never high.
REQ-034 Setup: oc_fault pulsed at timer_0 = 30 with on_time 120. Response: gate_0 low from clk 32 until the next cycle; the next pulse is a full 120. With oc_fault held high across the wrap, the gate stays low.
REQ-035 State sequence: state -> S_DEION mid-pulse, gate low next clk; back to 8'b00000010 at timer 200, no pulse until timer 0. With INTERLEAVE_PHASE1_EN, the gate_1 rising edge lags gate_0 by 200 clk.

Source files
------------

// File: rtl/buck_pkg.sv
// buck_pkg -- shared definitions for the buck PWM generator.
//   * Discharge-FSM state encodings (one-hot) seen on current_state.
//   * Default PWM timing (PERIOD, MAX_ON, MIN_ON) in clk cycles.
//   * buck_enable(): decides whether a state permits buck switching.
package buck_pkg;

    localparam int STATE_W = 8;
    localparam int TIME_W  = 16;

    typedef enum logic [STATE_W-1:0] {
        S_WAIT_BREAKDOWN  = 8'b0000_0001,
        S_BUCK_INTERLEAVE = 8'b0000_0010,
        S_DEION           = 8'b1000_0000
    } dis_state_e;

    localparam logic [TIME_W-1:0] PERIOD_DEF = 16'd400;  // 4 us at 100 MHz
    localparam logic [TIME_W-1:0] MAX_ON_DEF = 16'd360;
    localparam logic [TIME_W-1:0] MIN_ON_DEF = 16'd8;

    // Only the breakdown-wait and interleaved-buck states may drive the gates.
    function automatic logic buck_enable(input logic [STATE_W-1:0] st);
        return (st == S_WAIT_BREAKDOWN) || (st == S_BUCK_INTERLEAVE);
    endfunction

endpackage

// File: rtl/buck_pwm_gen_if.sv
// buck_pwm_gen_if -- signal bundle between the discharge controller and the
// buck PWM generator.
//   master : controller side (drives state, on-time requests, OC flag)
//   slave  : PWM generator side (drives timers, gates, cycle_start_0)
// Signals:
//   current_state    [8]  discharge FSM state, one-hot
//   charging_time_0  [16] requested phase-0 on-time (clk cycles)
//   charging_time_1  [16] requested phase-1 on-time (clk cycles)
//   oc_fault         [1]  overcurrent trip, high = trip
//   timer_buck_4us_0 [16] phase-0 period counter
//   timer_buck_4us_1 [16] phase-1 period counter (half-period offset)
//   gate_0 / gate_1  [1]  MOSFET gate drive, high = on
//   cycle_start_0    [1]  one-clk pulse while timer_buck_4us_0 == 0
interface buck_pwm_gen_if;
    import buck_pkg::*;

    logic [STATE_W-1:0] current_state;
    logic [TIME_W-1:0]  charging_time_0;
    logic [TIME_W-1:0]  charging_time_1;
    logic               oc_fault;
    logic [TIME_W-1:0]  timer_buck_4us_0;
    logic [TIME_W-1:0]  timer_buck_4us_1;
    logic               gate_0;
    logic               gate_1;
    logic               cycle_start_0;

    modport master (
        output current_state, charging_time_0, charging_time_1, oc_fault,
        input  timer_buck_4us_0, timer_buck_4us_1, gate_0, gate_1, cycle_start_0
    );

    modport slave (
        input  current_state, charging_time_0, charging_time_1, oc_fault,
        output timer_buck_4us_0, timer_buck_4us_1, gate_0, gate_1, cycle_start_0
    );

endinterface

// File: rtl/buck_pwm_phase.sv
// buck_pwm_phase -- one buck phase: free-running period timer, shadowed and
// clamped on-time, arm flag, overcurrent latch and registered gate.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   enable_i          switching permitted by the discharge FSM
//   charging_time_i   requested on-time, sampled once per period
//   oc_fault_i        overcurrent trip (synchronous)
//   timer_o           period counter, 0..PERIOD-1
//   gate_o            gate drive, high = on
// TIMER_INIT sets the counter value out of reset (phase offset).
module buck_pwm_phase
    import buck_pkg::*;
#(
    parameter logic [TIME_W-1:0] PERIOD     = PERIOD_DEF,
    parameter logic [TIME_W-1:0] MAX_ON     = MAX_ON_DEF,
    parameter logic [TIME_W-1:0] MIN_ON     = MIN_ON_DEF,
    parameter logic [TIME_W-1:0] TIMER_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [TIME_W-1:0] charging_time_i,
    input  logic              oc_fault_i,
    output logic [TIME_W-1:0] timer_o,
    output logic              gate_o
);

    // Zero stays zero (phase idle); tiny requests are raised to a usable
    // minimum; MAX_ON < PERIOD keeps an off interval in every period.
    function automatic logic [TIME_W-1:0] clamp_on_time(input logic [TIME_W-1:0] req);
        if (req == '0)
            return '0;
        else if (req < MIN_ON)
            return MIN_ON;
        else if (req > MAX_ON)
            return MAX_ON;
        else
            return req;
    endfunction

    logic [TIME_W-1:0] timer_q,   timer_d;
    logic [TIME_W-1:0] on_time_q, on_time_d;
    logic              arm_q,     arm_d;
    logic              oc_latch_q, oc_latch_d;
    logic              gate_q,    gate_d;
    logic              wrap;

    // Last count of the period: the boundary where new settings take over.
    assign wrap = (timer_q == PERIOD - 16'd1);

    always_comb begin
        timer_d = wrap ? '0 : timer_q + 16'd1;

        // Shadow register: the request only matters on the last count, so
        // mid-period changes wait for the next period.
        on_time_d = wrap ? clamp_on_time(charging_time_i) : on_time_q;

        // Arming only at the boundary prevents a partial pulse when enable
        // rises mid-period; losing enable disarms at once.
        if (!enable_i)
            arm_d = 1'b0;
        else if (wrap)
            arm_d = 1'b1;
        else
            arm_d = arm_q;

        // A trip on the boundary count beats the per-period clear.
        if (oc_fault_i)
            oc_latch_d = 1'b1;
        else if (wrap)
            oc_latch_d = 1'b0;
        else
            oc_latch_d = oc_latch_q;

        gate_d = arm_q & enable_i & (timer_q < on_time_q) & ~oc_latch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= TIMER_INIT;
            on_time_q  <= '0;
            arm_q      <= 1'b0;
            oc_latch_q <= 1'b0;
            gate_q     <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            on_time_q  <= on_time_d;
            arm_q      <= arm_d;
            oc_latch_q <= oc_latch_d;
            gate_q     <= gate_d;
        end
    end

    assign timer_o = timer_q;
    assign gate_o  = gate_q;

endmodule

// File: rtl/buck_pwm_gen.sv
// buck_pwm_gen -- buck converter PWM generator, one or two interleaved phases.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    buck_pwm_gen_if.slave (state, on-time requests, OC flag in;
//          timers, gates, cycle_start_0 out)
// Configuration macro INTERLEAVE_PHASE1_EN:
//   defined   -> phase 1 runs half a period behind phase 0
//   undefined -> timer_buck_4us_1 and gate_1 are tied to 0 and
//                charging_time_1 is ignored
module buck_pwm_gen
    import buck_pkg::*;
#(
    parameter logic [TIME_W-1:0] PERIOD = PERIOD_DEF,
    parameter logic [TIME_W-1:0] MAX_ON = MAX_ON_DEF,
    parameter logic [TIME_W-1:0] MIN_ON = MIN_ON_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    buck_pwm_gen_if.slave  bus
);

    logic              enable;
    logic [TIME_W-1:0] timer_0;
    logic              gate_0;
    logic              cycle_start_q, cycle_start_d;

    assign enable = buck_enable(bus.current_state);

    buck_pwm_phase #(
        .PERIOD     (PERIOD),
        .MAX_ON     (MAX_ON),
        .MIN_ON     (MIN_ON),
        .TIMER_INIT ('0)
    ) u_phase0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable),
        .charging_time_i (bus.charging_time_0),
        .oc_fault_i      (bus.oc_fault),
        .timer_o         (timer_0),
        .gate_o          (gate_0)
    );

    // Registered so that it is low in reset even though the timer sits at 0;
    // it is high exactly while the timer shows 0 after a wrap.
    assign cycle_start_d = (timer_0 == PERIOD - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cycle_start_q <= 1'b0;
        else
            cycle_start_q <= cycle_start_d;
    end

    assign bus.timer_buck_4us_0 = timer_0;
    assign bus.gate_0           = gate_0;
    assign bus.cycle_start_0    = cycle_start_q;

`ifdef INTERLEAVE_PHASE1_EN
    logic [TIME_W-1:0] timer_1;
    logic              gate_1;

    buck_pwm_phase #(
        .PERIOD     (PERIOD),
        .MAX_ON     (MAX_ON),
        .MIN_ON     (MIN_ON),
        .TIMER_INIT (PERIOD >> 1)
    ) u_phase1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable),
        .charging_time_i (bus.charging_time_1),
        .oc_fault_i      (bus.oc_fault),
        .timer_o         (timer_1),
        .gate_o          (gate_1)
    );

    assign bus.timer_buck_4us_1 = timer_1;
    assign bus.gate_1           = gate_1;
`else
    logic unused_charging_time_1;
    assign unused_charging_time_1 = ^bus.charging_time_1;

    assign bus.timer_buck_4us_1 = '0;
    assign bus.gate_1           = 1'b0;
`endif

endmodule

// File: tb/tb_buck_pwm_gen.sv
// tb_buck_pwm_gen -- self-checking bench for buck_pwm_gen (default parameters).
// Honours INTERLEAVE_PHASE1_EN the same way as the design.
`timescale 1ns/1ps
module tb_buck_pwm_gen;
    import buck_pkg::*;

    localparam int P     = 400;
    localparam int H     = 200;
    localparam int MINON = 8;
    localparam int MAXON = 360;

    typedef struct {
        int t0;
        int t1;
        bit g0;
        bit g1;
        bit cs;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    buck_pwm_gen_if bus();

    buck_pwm_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   errs   = 0;
    int   checks = 0;
    int   j      = 0;       // cycles since reset release
    exp_t exp_q[$];
    bit   en_h[$];
    bit   oc_h[$];
    int   ct0_h[$];
    int   ct1_h[$];

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, j);
        end
    endtask

    function automatic int clamp(input int v);
        if (v == 0)     return 0;
        if (v < MINON)  return MINON;
        if (v > MAXON)  return MAXON;
        return v;
    endfunction

    // Gate level produced by the conditions of cycle jj. The period holding
    // jj starts at s; its settings were taken on cycle w = s-1. The gate is on
    // iff enable held from w through jj, no trip occurred from w to jj-1 and
    // the position lies inside the clamped on-time requested on cycle w.
    function automatic bit model_gate(input int off, input bit ph1, input int jj);
        int p, s, w;
        p = (jj + off) % P;
        s = jj - p;
        if (s <= 0) return 1'b0;
        w = s - 1;
        for (int i = w; i <= jj; i++) if (!en_h[i]) return 1'b0;
        for (int i = w; i < jj; i++)  if (oc_h[i])  return 1'b0;
        return p < clamp(ph1 ? ct1_h[w] : ct0_h[w]);
    endfunction

    task automatic push_expected();
        exp_t e;
        e.t0 = j % P;
        e.g0 = (j > 0) ? model_gate(0, 1'b0, j - 1) : 1'b0;
        e.cs = (j > 0) && (j % P == 0);
`ifdef INTERLEAVE_PHASE1_EN
        e.t1 = (j + H) % P;
        e.g1 = (j > 0) ? model_gate(H, 1'b1, j - 1) : 1'b0;
`else
        e.t1 = 0;
        e.g1 = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic start_model();
        j = 0;
        en_h.delete(); oc_h.delete(); ct0_h.delete(); ct1_h.delete();
        push_expected();
    endtask

    task automatic next_cycle();
        en_h.push_back(buck_enable(bus.current_state));
        oc_h.push_back(bus.oc_fault);
        ct0_h.push_back(int'(bus.charging_time_0));
        ct1_h.push_back(int'(bus.charging_time_1));
        @(posedge clk);
        #1;
        j++;
        push_expected();
    endtask

    task automatic run(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < P && (j % P) != pos; k++) next_cycle();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_timer0"}, int'(bus.timer_buck_4us_0), 0);
`ifdef INTERLEAVE_PHASE1_EN
        check({tag, "_timer1"}, int'(bus.timer_buck_4us_1), H);
`else
        check({tag, "_timer1"}, int'(bus.timer_buck_4us_1), 0);
`endif
        check({tag, "_gate0"}, int'(bus.gate_0), 0);
        check({tag, "_gate1"}, int'(bus.gate_1), 0);
        check({tag, "_cs0"},   int'(bus.cycle_start_0), 0);
    endtask

    // Asynchronous reset asserted mid-cycle, gates must drop without a clock.
    task automatic do_reset();
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_model();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("timer0", int'(bus.timer_buck_4us_0), e.t0);
            check("timer1", int'(bus.timer_buck_4us_1), e.t1);
            check("gate0",  int'(bus.gate_0), int'(e.g0));
            check("gate1",  int'(bus.gate_1), int'(e.g1));
            check("cs0",    int'(bus.cycle_start_0), int'(e.cs));
        end
    end

    logic [7:0] rnd_states [4] = '{8'b0000_0001, 8'b0000_0010, 8'b1000_0000, 8'b0000_0100};

    initial begin
        bus.current_state   = S_BUCK_INTERLEAVE;
        bus.charging_time_0 = 16'd120;
        bus.charging_time_1 = 16'd200;
        bus.oc_fault        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        start_model();

        // steady 120-cycle pulses
        run(3 * P);

        // mid-period request change only lands next period
        run_to(50);
        bus.charging_time_0 = 16'd80;
        bus.charging_time_1 = 16'd40;
        run(2 * P);

        // clamp corners
        bus.charging_time_0 = 16'd3;   bus.charging_time_1 = 16'd1;   run(P);
        bus.charging_time_0 = 16'd500; bus.charging_time_1 = 16'd361; run(P);
        bus.charging_time_0 = 16'd0;   bus.charging_time_1 = 16'd360; run(P);

        // overcurrent pulse at timer 30, then held across the wrap
        bus.charging_time_0 = 16'd120; bus.charging_time_1 = 16'd120;
        run(P);
        run_to(30);
        bus.oc_fault = 1'b1;
        next_cycle();
        bus.oc_fault = 1'b0;
        run_to(390);
        bus.oc_fault = 1'b1;
        run(20);
        bus.oc_fault = 1'b0;
        run(P);

        // de-ionise mid-pulse, resume mid-period
        run_to(60);
        bus.current_state = S_DEION;
        run_to(200);
        bus.current_state = S_BUCK_INTERLEAVE;
        run(2 * P);

        // wait-breakdown state also enables switching
        bus.current_state   = S_WAIT_BREAKDOWN;
        bus.charging_time_0 = 16'($urandom_range(0, 400));
        bus.charging_time_1 = 16'($urandom_range(0, 400));
        run(2 * P);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) bus.charging_time_0 = 16'($urandom_range(0, 600));
            if ($urandom_range(0, 149) == 0) bus.charging_time_1 = 16'($urandom_range(0, 600));
            if ($urandom_range(0, 999) == 0) bus.charging_time_0 = 16'hFFFF;
            if ($urandom_range(0, 249) == 0) bus.current_state = rnd_states[$urandom_range(0, 3)];
            bus.oc_fault = ($urandom_range(0, 299) == 0);
            next_cycle();
        end
        bus.oc_fault        = 1'b0;
        bus.current_state   = S_BUCK_INTERLEAVE;
        bus.charging_time_0 = 16'd120;
        bus.charging_time_1 = 16'd150;
        run(P);

        // reset in the middle of a pulse, then recovery
        run_to(50);
        do_reset();
        run(3 * P);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
